// File: rtl/rv32i_mc_control_if.sv
// Control-sequencer <-> datapath/memory bundle for the multi-cycle rv32i core.
// master = the sequencer, slave = the datapath/memory side that feeds it.
interface rv32i_mc_control_if #(
    parameter int CNT_WIDTH = 32
);
    logic [31:0]          instr;
    logic                 branch_taken;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 mem_we;
    logic                 ir_write;
    logic                 pc_write;
    logic [1:0]           pc_sel;
    logic                 reg_write;
    logic [1:0]           wb_sel;
    logic [2:0]           imm_src;
    logic                 illegal;
    logic [CNT_WIDTH-1:0] instret;

    modport master (
        input  instr, branch_taken, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, pc_sel, reg_write,
               wb_sel, imm_src, illegal, instret
    );

    modport slave (
        output instr, branch_taken, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, pc_sel, reg_write,
               wb_sel, imm_src, illegal, instret
    );
endinterface

// File: rtl/rv32i_mc_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the shared rv32i datapath,
// with a retired-instruction counter and a sticky illegal-opcode trap.
module rv32i_mc_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    rv32i_mc_control_if.master  bus
);
    typedef enum logic [2:0] {RST_IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    typedef enum logic [3:0] {
        CL_NONE, CL_R, CL_OPIMM, CL_LOAD, CL_JALR, CL_STORE,
        CL_BRANCH, CL_JAL, CL_LUI, CL_AUIPC
    } class_t;

    state_t               state_reg, state_next;
    class_t               class_reg, class_dec;
    logic                 illegal_reg;
    logic [CNT_WIDTH-1:0] instret_reg;

    logic       mem_req, mem_we, ir_write, pc_write, reg_write;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] imm_src;

    function automatic logic [2:0] imm_of(input class_t c);
        case (c)
            CL_OPIMM, CL_LOAD, CL_JALR: imm_of = 3'b000;
            CL_STORE:                   imm_of = 3'b001;
            CL_BRANCH:                  imm_of = 3'b010;
            CL_JAL:                     imm_of = 3'b011;
            CL_LUI, CL_AUIPC:           imm_of = 3'b100;
            default:                    imm_of = 3'b000;
        endcase
    endfunction

    // CL_NONE doubles as the "unrecognised opcode" marker
    always_comb begin
        class_dec = CL_NONE;
        case (bus.instr[6:0])
            7'b0110111: class_dec = CL_LUI;
            7'b0010111: class_dec = CL_AUIPC;
            7'b1101111: class_dec = CL_JAL;
            7'b1100111: class_dec = CL_JALR;
            7'b0000011: class_dec = CL_LOAD;
            7'b0010011: class_dec = CL_OPIMM;
            7'b0100011: class_dec = CL_STORE;
            7'b1100011: class_dec = CL_BRANCH;
            7'b0110011: class_dec = CL_R;
            default:    class_dec = CL_NONE;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 2'b00;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        imm_src    = 3'b000;
        case (state_reg)
            RST_IDLE: state_next = FETCH;
            FETCH: begin
                mem_req  = 1'b1;
                ir_write = bus.mem_ready;
                if (bus.mem_ready) state_next = DECODE;
            end
            DECODE: begin
                imm_src    = imm_of(class_dec);
                state_next = (class_dec == CL_NONE) ? TRAP : EXEC;
            end
            EXEC: begin
                imm_src = imm_of(class_reg);
                case (class_reg)
                    CL_LOAD, CL_STORE: state_next = MEM;
                    CL_BRANCH: begin
                        pc_write   = 1'b1;
                        pc_sel     = bus.branch_taken ? 2'b01 : 2'b00;
                        state_next = FETCH;
                    end
                    default: state_next = WB;
                endcase
            end
            MEM: begin
                imm_src = imm_of(class_reg);
                mem_req = 1'b1;
                mem_we  = (class_reg == CL_STORE);
                if (bus.mem_ready) begin
                    if (class_reg == CL_STORE) begin
                        pc_write   = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB: begin
                imm_src   = imm_of(class_reg);
                reg_write = 1'b1;
                pc_write  = 1'b1;
                case (class_reg)
                    CL_JAL:  begin pc_sel = 2'b01; wb_sel = 2'b10; end
                    CL_JALR: begin pc_sel = 2'b10; wb_sel = 2'b10; end
                    CL_LOAD: wb_sel = 2'b01;
                    CL_LUI:  wb_sel = 2'b11;
                    default: wb_sel = 2'b00;
                endcase
                state_next = FETCH;
            end
            TRAP:    state_next = TRAP;
            default: state_next = RST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= RST_IDLE;
            class_reg   <= CL_NONE;
            illegal_reg <= 1'b0;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE) begin
                class_reg <= class_dec;
                if (class_dec == CL_NONE) illegal_reg <= 1'b1;
            end
            if (pc_write) instret_reg <= instret_reg + 1'b1;
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.ir_write  = ir_write;
    assign bus.pc_write  = pc_write;
    assign bus.pc_sel    = pc_sel;
    assign bus.reg_write = reg_write;
    assign bus.wb_sel    = wb_sel;
    assign bus.imm_src   = imm_src;
    assign bus.illegal   = illegal_reg;
    assign bus.instret   = instret_reg;
endmodule

// File: tb/tb_rv32i_mc_control.sv
// Scoreboard bench for rv32i_mc_control: per-instruction expectations are queued
// when an instruction is issued and compared when it retires (pc_write).
module tb_rv32i_mc_control;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32i_mc_control_if #(.CNT_WIDTH(32)) bus ();

    rv32i_mc_control #(.CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [1:0] pc_sel;
        logic [1:0] wb_sel;
        logic [2:0] imm;
        logic       rw;
        logic       we;
        int         mem_cyc;
        int         cycles;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   failures  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered just after a posedge that left the DUT in FETCH.
    // fw = fetch wait cycles, mw = MEM wait cycles.
    task automatic run_instr(input logic [31:0] ins, input logic taken, input int fw, input int mw,
                             input logic [1:0] pcs, input logic [1:0] wbs, input logic [2:0] imm,
                             input logic rw, input logic we, input int mem_cyc, input int cycles);
        exp_t        e;
        int          cyc = 0;
        int          ircnt = 0, ircyc = 0, rwcnt = 0, memcyc = 0;
        bit          we_seen = 0, conflict = 0, done = 0;
        logic [2:0]  imm_dec = '0, imm_ret = '0;
        logic [1:0]  pcs_o = '0, wbs_o = '0;
        logic [31:0] inst0;
        e.pc_sel = pcs; e.wb_sel = wbs; e.imm = imm; e.rw = rw; e.we = we;
        e.mem_cyc = mem_cyc; e.cycles = cycles;
        sb_q.push_back(e);
        inst0 = bus.instret;
        bus.instr = ins;
        bus.branch_taken = taken;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus.mem_ready = !((cyc <= fw) || (cyc > fw + 3 && cyc <= fw + 3 + mw));
            #1;
            if (bus.ir_write) begin ircnt++; ircyc = cyc; end
            if (cyc == fw + 2) imm_dec = bus.imm_src;
            if (bus.mem_req && cyc > fw + 1) memcyc++;
            if (bus.mem_req && bus.mem_we) we_seen = 1;
            if (bus.reg_write) rwcnt++;
            if (bus.reg_write && bus.mem_we) conflict = 1;
            if (bus.pc_write) begin
                done = 1;
                pcs_o = bus.pc_sel;
                wbs_o = bus.wb_sel;
                imm_ret = bus.imm_src;
            end
        end
        bus.mem_ready = 1'b1;
        e = sb_q.pop_front();
        check("retire_seen", done, 1);
        check("cycles", cyc, e.cycles);
        check("ir_write_count", ircnt, 1);
        check("ir_write_cycle", ircyc, fw + 1);
        check("imm_decode", imm_dec, e.imm);
        check("imm_retire", imm_ret, e.imm);
        check("pc_sel", pcs_o, e.pc_sel);
        check("wb_sel", wbs_o, e.wb_sel);
        check("reg_write_count", rwcnt, e.rw ? 1 : 0);
        check("mem_we_seen", we_seen, e.we);
        check("mem_cycles", memcyc, e.mem_cyc);
        check("rw_we_conflict", conflict, 0);
        @(posedge clk);
        #1;
        check("instret_inc", bus.instret, inst0 + 32'd1);
        $display("[TB] instr %08h retired after %0d cycles, instret=%0d", ins, cyc, bus.instret);
    endtask

    initial begin
        logic [4:0] strobes;
        logic [31:0] inst_trap;
        rst = 1'b1;
        bus.instr = '0;
        bus.branch_taken = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_outputs", {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.pc_sel,
                              bus.reg_write, bus.wb_sel, bus.imm_src, bus.illegal}, 0);
        check("rst_instret", bus.instret, 0);
        rst = 1'b0;
        #1;
        check("idle_outputs", {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.pc_sel,
                               bus.reg_write, bus.wb_sel, bus.imm_src, bus.illegal}, 0);
        @(posedge clk);

        //        instr         tk fw mw  pcs    wbs    imm     rw  we  memc cyc
        run_instr(32'h00500093, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0, 0, 4); // addi
        run_instr(32'h0000A103, 0, 0, 3, 2'b00, 2'b01, 3'b000, 1, 0, 4, 8); // lw, 3 waits
        run_instr(32'h00112223, 0, 0, 0, 2'b00, 2'b00, 3'b001, 0, 1, 1, 4); // sw
        run_instr(32'h00208463, 1, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0, 0, 3); // beq taken
        run_instr(32'h00208463, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0, 0, 3); // beq not taken
        run_instr(32'h008000EF, 0, 0, 0, 2'b01, 2'b10, 3'b011, 1, 0, 0, 4); // jal
        run_instr(32'h123450B7, 0, 0, 0, 2'b00, 2'b11, 3'b100, 1, 0, 0, 4); // lui
        run_instr(32'h000080E7, 0, 0, 0, 2'b10, 2'b10, 3'b000, 1, 0, 0, 4); // jalr
        run_instr(32'h00000097, 0, 0, 0, 2'b00, 2'b00, 3'b100, 1, 0, 0, 4); // auipc
        run_instr(32'h002081B3, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0, 0, 4); // add
        run_instr(32'h0000A103, 0, 0, 0, 2'b00, 2'b01, 3'b000, 1, 0, 1, 5); // lw, no wait
        run_instr(32'h00112223, 0, 0, 2, 2'b00, 2'b00, 3'b001, 0, 1, 3, 6); // sw, 2 waits
        run_instr(32'h00500093, 0, 2, 0, 2'b00, 2'b00, 3'b000, 1, 0, 0, 6); // addi, 2 fetch waits

        // Illegal opcode: FETCH, DECODE, then TRAP forever
        inst_trap = bus.instret;
        bus.instr = 32'h0000007F;
        strobes = '0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            bus.mem_ready = (c == 1) ? 1'b1 : c[0];
            #1;
            if (c == 2) check("trap_decode_imm", bus.imm_src, 3'b000);
            if (c == 3) check("trap_illegal_set", bus.illegal, 1);
            if (c >= 3) strobes |= {bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_we};
        end
        check("trap_strobes", strobes, 0);
        check("trap_illegal_sticky", bus.illegal, 1);
        check("trap_instret", bus.instret, inst_trap);
        $display("[TB] instr 0000007f trapped, illegal=%0b", bus.illegal);

        // Reset out of TRAP clears the trap and the counter
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("trap_rst_illegal", bus.illegal, 0);
        check("trap_rst_instret", bus.instret, 0);
        #2;
        rst = 1'b0;
        @(posedge clk);

        // Reset mid-FETCH drops mem_req without waiting for a clock
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.instr = 32'h00500093;
        #1;
        check("midfetch_req", bus.mem_req, 1);
        rst = 1'b1;
        #1;
        check("abort_req", bus.mem_req, 0);
        strobes = '0;
        repeat (2) begin
            @(negedge clk); #1;
            strobes |= {bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_we};
        end
        check("abort_strobes", strobes, 0);
        check("abort_instret", bus.instret, 0);
        $display("[TB] fetch aborted by reset, mem_req=%0b", bus.mem_req);
        bus.mem_ready = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        run_instr(32'h00500093, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0, 0, 4);
        check("post_reset_instret", bus.instret, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
